// File: rtl/uart_tx.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       Busy,
  output logic       HOLD_FULL
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [2:0] bit_cnt;
  logic [2:0] next_cnt;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic       next_tx;
  logic       load_input;
  logic       parity_bit;

  assign parity_bit = par_typ_q ? ~(^data_q) : (^data_q);

`ifdef UART_TX_HOLD_EN
  logic [7:0] hold_data;
  logic       hold_par_en;
  logic       hold_par_typ;
  logic       hold_full_q;
  logic       load_hold;
  logic       hold_accept;

  // STOP is excluded: an empty hold in STOP starts the next frame directly instead.
  assign hold_accept = Data_Valid && Busy && !hold_full_q && (state != STOP);
  assign HOLD_FULL   = hold_full_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_full_q  <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_typ <= 1'b0;
    end else if (load_hold) begin
      hold_full_q <= 1'b0;
    end else if (hold_accept) begin
      hold_full_q  <= 1'b1;
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_typ <= PAR_TYP;
    end
  end
`else
  assign HOLD_FULL = 1'b0;
`endif

  // next_tx is the bit the line will carry while in next_state, so TX_OUT is registered.
  always_comb begin
    next_state = state;
    next_cnt   = bit_cnt;
    next_tx    = 1'b1;
    load_input = 1'b0;
`ifdef UART_TX_HOLD_EN
    load_hold  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Data_Valid) begin
          next_state = START;
          next_tx    = 1'b0;
          load_input = 1'b1;
        end
      end
      START: begin
        next_state = DATA;
        next_cnt   = 3'd0;
        next_tx    = data_q[0];
      end
      DATA: begin
        if (bit_cnt == 3'd7) begin
          if (par_en_q) begin
            next_state = PARITY;
            next_tx    = parity_bit;
          end else begin
            next_state = STOP;
            next_tx    = 1'b1;
          end
        end else begin
          next_cnt = bit_cnt + 3'd1;
          next_tx  = data_q[bit_cnt + 3'd1];
        end
      end
      PARITY: begin
        next_state = STOP;
        next_tx    = 1'b1;
      end
      STOP: begin
`ifdef UART_TX_HOLD_EN
        if (hold_full_q) begin
          next_state = START;
          next_tx    = 1'b0;
          load_hold  = 1'b1;
        end else if (Data_Valid) begin
          next_state = START;
          next_tx    = 1'b0;
          load_input = 1'b1;
        end else begin
          next_state = IDLE;
        end
`else
        next_state = IDLE;
`endif
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
    end else begin
      state   <= next_state;
      bit_cnt <= next_cnt;
      TX_OUT  <= next_tx;
      Busy    <= (next_state != IDLE);
      if (load_input) begin
        data_q    <= P_DATA;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
`ifdef UART_TX_HOLD_EN
      else if (load_hold) begin
        data_q    <= hold_data;
        par_en_q  <= hold_par_en;
        par_typ_q <= hold_par_typ;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed frames plus randomized frames against a
// queue-based frame model; the hold scenario is built only with UART_TX_HOLD_EN.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;
  logic       HOLD_FULL;

  int checks = 0;
  int failures = 0;

  logic exp_bits[$];
  logic tx_seen[$];
  logic busy_seen[$];
  logic hold_seen[$];

  uart_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy),
    .HOLD_FULL (HOLD_FULL)
  );

  always #5 CLK = ~CLK;

  // Reference frame: the parity bit makes the total count of ones even (or odd).
  function automatic void append_frame(input logic [7:0] d, input logic pe, input logic pt);
    int ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) exp_bits.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    exp_bits.push_back(1'b1);
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Data_Valid = 1'b1;
    @(posedge CLK);
    #1;
    Data_Valid = 1'b0;
    P_DATA     = 8'($urandom);
    PAR_EN     = 1'($urandom);
    PAR_TYP    = 1'($urandom);
  endtask

  task automatic capture(input int n);
    tx_seen.delete();
    busy_seen.delete();
    hold_seen.delete();
    repeat (n) begin
      @(negedge CLK);
      tx_seen.push_back(TX_OUT);
      busy_seen.push_back(Busy);
      hold_seen.push_back(HOLD_FULL);
    end
  endtask

  task automatic test_reset();
    RST        = 1'b0;
    Data_Valid = 1'b1;
    P_DATA     = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_tx cycle%0d got=%b want=1", i, TX_OUT);
      end
      checks++;
      if (Busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_busy cycle%0d got=%b want=0", i, Busy);
      end
      checks++;
      if (HOLD_FULL !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold cycle%0d got=%b want=0", i, HOLD_FULL);
      end
    end
    Data_Valid = 1'b0;
    RST        = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_known_frames();
    logic want_a5_even[$] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic want_a5_odd[$]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic want_3c[$]      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic want[$];
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin want = want_a5_even; start_frame(8'hA5, 1'b1, 1'b0); end
        1: begin want = want_a5_odd;  start_frame(8'hA5, 1'b1, 1'b1); end
        default: begin want = want_3c; start_frame(8'h3C, 1'b0, 1'b0); end
      endcase
      capture(want.size() + 1);
      for (int i = 0; i <= want.size(); i++) begin
        checks++;
        if (tx_seen[i] !== ((i < want.size()) ? want[i] : 1'b1)) begin
          failures++;
          $display("[TB] FAIL known%0d_tx bit%0d got=%b want=%b", t, i, tx_seen[i],
                   (i < want.size()) ? want[i] : 1'b1);
        end
        checks++;
        if (busy_seen[i] !== (i < want.size())) begin
          failures++;
          $display("[TB] FAIL known%0d_busy cycle%0d got=%b want=%b", t, i, busy_seen[i],
                   i < want.size());
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    logic       pe;
    logic       pt;
    repeat (25) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      exp_bits.delete();
      append_frame(d, pe, pt);
      start_frame(d, pe, pt);
      capture(exp_bits.size() + 1);
      for (int i = 0; i <= exp_bits.size(); i++) begin
        checks++;
        if (tx_seen[i] !== ((i < exp_bits.size()) ? exp_bits[i] : 1'b1)) begin
          failures++;
          $display("[TB] FAIL rand_tx data=%02h pe=%b pt=%b bit%0d got=%b want=%b", d, pe, pt, i,
                   tx_seen[i], (i < exp_bits.size()) ? exp_bits[i] : 1'b1);
        end
        checks++;
        if (busy_seen[i] !== (i < exp_bits.size())) begin
          failures++;
          $display("[TB] FAIL rand_busy data=%02h cycle%0d got=%b want=%b", d, i, busy_seen[i],
                   i < exp_bits.size());
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

`ifndef UART_TX_HOLD_EN
  task automatic test_ignore_busy();
    exp_bits.delete();
    append_frame(8'h0F, 1'b0, 1'b0);
    start_frame(8'h0F, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== ((i < 10) ? exp_bits[i] : 1'b1)) begin
        failures++;
        $display("[TB] FAIL ignore_tx bit%0d got=%b want=%b", i, TX_OUT,
                 (i < 10) ? exp_bits[i] : 1'b1);
      end
      checks++;
      if (Busy !== (i < 10)) begin
        failures++;
        $display("[TB] FAIL ignore_busy cycle%0d got=%b want=%b", i, Busy, i < 10);
      end
      if (i == 4) begin
        P_DATA     = 8'h55;
        Data_Valid = 1'b1;
      end
      if (i == 5) Data_Valid = 1'b0;
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom);
    exp_bits.delete();
    append_frame(d, 1'b1, 1'b0);
    start_frame(d, 1'b1, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== exp_bits[i]) begin
        failures++;
        $display("[TB] FAIL abort_pre_tx bit%0d got=%b want=%b", i, TX_OUT, exp_bits[i]);
      end
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_tx got=%b want=1", TX_OUT);
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_busy got=%b want=0", Busy);
    end
    RST = 1'b1;
    @(negedge CLK);
    exp_bits.delete();
    append_frame(8'h81, 1'b1, 1'b0);
    start_frame(8'h81, 1'b1, 1'b0);
    capture(exp_bits.size() + 1);
    for (int i = 0; i <= exp_bits.size(); i++) begin
      checks++;
      if (tx_seen[i] !== ((i < exp_bits.size()) ? exp_bits[i] : 1'b1)) begin
        failures++;
        $display("[TB] FAIL after_abort_tx bit%0d got=%b want=%b", i, tx_seen[i],
                 (i < exp_bits.size()) ? exp_bits[i] : 1'b1);
      end
      checks++;
      if (busy_seen[i] !== (i < exp_bits.size())) begin
        failures++;
        $display("[TB] FAIL after_abort_busy cycle%0d got=%b want=%b", i, busy_seen[i],
                 i < exp_bits.size());
      end
    end
  endtask

  task automatic test_parity_latch();
    logic [7:0] d;
    logic       pt;
    repeat (4) begin
      d  = 8'($urandom);
      pt = 1'($urandom);
      exp_bits.delete();
      append_frame(d, 1'b1, pt);
      start_frame(d, 1'b1, pt);
      PAR_TYP = ~pt;
      for (int i = 0; i < 12; i++) begin
        @(negedge CLK);
        checks++;
        if (TX_OUT !== ((i < 11) ? exp_bits[i] : 1'b1)) begin
          failures++;
          $display("[TB] FAIL par_latch data=%02h pt=%b bit%0d got=%b want=%b", d, pt, i, TX_OUT,
                   (i < 11) ? exp_bits[i] : 1'b1);
        end
        PAR_TYP = ~PAR_TYP;
        P_DATA  = 8'($urandom);
      end
    end
  endtask

`ifdef UART_TX_HOLD_EN
  task automatic test_back_to_back();
    exp_bits.delete();
    append_frame(8'h01, 1'b0, 1'b0);
    append_frame(8'h80, 1'b0, 1'b0);
    start_frame(8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 21; i++) begin
      @(negedge CLK);
      checks++;
      if (TX_OUT !== ((i < 20) ? exp_bits[i] : 1'b1)) begin
        failures++;
        $display("[TB] FAIL b2b_tx bit%0d got=%b want=%b", i, TX_OUT,
                 (i < 20) ? exp_bits[i] : 1'b1);
      end
      checks++;
      if (Busy !== (i < 20)) begin
        failures++;
        $display("[TB] FAIL b2b_busy cycle%0d got=%b want=%b", i, Busy, i < 20);
      end
      checks++;
      if (HOLD_FULL !== (i >= 4 && i <= 9)) begin
        failures++;
        $display("[TB] FAIL b2b_hold cycle%0d got=%b want=%b", i, HOLD_FULL, i >= 4 && i <= 9);
      end
      if (i == 3) begin
        P_DATA     = 8'h80;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Data_Valid = 1'b1;
      end
      if (i == 4) Data_Valid = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_known_frames();
    test_random_frames();
`ifndef UART_TX_HOLD_EN
    test_ignore_busy();
`endif
    test_reset_mid_frame();
    test_parity_latch();
`ifdef UART_TX_HOLD_EN
    test_back_to_back();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have port CLK, input, 1 bit: bit-rate clock, one serial bit per cycle, all logic on rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port P_DATA, input, 8 bits: parallel byte to transmit, sampled only at accept.
REQ-004 SHALL have port Data_Valid, input, 1 bit: P_DATA valid request.
REQ-005 SHALL have port PAR_EN, input, 1 bit: 1 = parity bit inserted, sampled at accept.
REQ-006 SHALL have port PAR_TYP, input, 1 bit: 0 = even, 1 = odd, sampled at accept.
REQ-007 SHALL have port TX_OUT, output, 1 bit: registered serial line, idle high.
REQ-008 SHALL have port Busy, output, 1 bit: registered, 1 while a frame is in progress.
REQ-009 SHALL have port HOLD_FULL, output, 1 bit: registered, 1 while holding register occupied (tied 0 when feature compiled out).

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-011 SHALL send frame: start bit 0, P_DATA[0] through P_DATA[7] LSB first, parity bit if PAR_EN, stop bit 1.
REQ-012 SHALL hold each bit on TX_OUT for exactly one CLK cycle (frame 11 cycles with parity, 10 without).
REQ-013 SHALL compute parity as XOR-reduce of the byte for even, its inverse for odd.
REQ-014 SHALL accept in IDLE when Data_Valid=1 at a rising edge: latch P_DATA, PAR_EN, PAR_TYP; go to START; Busy=1 from the next cycle.
REQ-015 SHALL drive start bit on TX_OUT in the cycle after the accept edge (latency 1).
REQ-016 SHALL transition START->DATA; DATA (3-bit counter 0..7) ->PARITY if latched PAR_EN else ->STOP after bit 7; PARITY->STOP.
REQ-017 SHALL, from STOP with no pending word, go to IDLE: TX_OUT=1, Busy=0.
REQ-018 SHALL ignore Data_Valid while Busy=1 unless the holding feature is compiled in (REQ-025).
REQ-019 SHALL leave the latched byte and config unaffected by input changes mid-frame.
REQ-020 SHALL keep TX_OUT=1 in IDLE regardless of PAR_EN and PAR_TYP.

Reset
REQ-021 SHALL, on RST=0 at a rising edge, force state IDLE, TX_OUT=1, Busy=0, HOLD_FULL=0, and clear bit counter and hold register.
REQ-022 SHALL abort any frame in progress on reset; TX_OUT returns high the cycle after the reset edge.
REQ-023 SHALL ignore Data_Valid during any cycle with RST=0.

Configuration
REQ-024 SHALL provide macro UART_TX_HOLD_EN to compile in a one-entry holding register.
REQ-025 SHALL, with UART_TX_HOLD_EN defined and Busy=1, HOLD_FULL=0, accept Data_Valid into the hold register (byte and PAR_EN/PAR_TYP); HOLD_FULL=1 next cycle.
REQ-026 SHALL, with UART_TX_HOLD_EN, go STOP->START directly when HOLD_FULL=1, loading hold into shift register, clearing HOLD_FULL; no idle cycle between frames.
REQ-027 SHALL, with UART_TX_HOLD_EN, ignore Data_Valid while HOLD_FULL=1, including the STOP cycle in which the hold register drains.
REQ-028 SHALL, without UART_TX_HOLD_EN, contain no hold register, tie HOLD_FULL to 0, and behave per REQ-018.

Verification
REQ-029 SHALL verify: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles from cycle after accept; Busy high exactly those 11 cycles.
REQ-030 SHALL verify: 0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit 1; 0x3C, PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1.
REQ-031 SHALL verify: Data_Valid with 0x55 during data bit 3 of frame 0x0F (no hold) -> ignored; only 0x0F sent, then TX_OUT idle high.
REQ-032 SHALL verify: RST=0 during data bit 5 -> TX_OUT=1, Busy=0 next cycle; new 0x81 after release sent as a complete correct frame.
REQ-033 SHALL verify with UART_TX_HOLD_EN: 0x01 then 0x80 (during frame 1), PAR_EN=0 -> 20 contiguous bit cycles, no idle gap; HOLD_FULL high from accept of 0x80 until frame-2 start.
REQ-034 SHALL verify: PAR_TYP toggled mid-frame -> parity bit uses value latched at accept.
